icache_ctrl: RTL and testbench

//   Direct-mapped, one-word-per-line instruction cache with a refill controller, between the IF stage and ctrl_mem's instruction port.

---
 rtl/icache_ctrl_pkg.sv | 16 +
 rtl/icache_store.sv | 60 ++++++
 rtl/icache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_icache_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared constants and types for the instruction cache and its refill controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_ctrl_pkg;

  localparam int ICACHE_ADDR_WIDTH = 32;
  localparam int ICACHE_INDEX_BITS = 7;
  localparam int ICACHE_DATA_WIDTH = 32;

  // One bit is enough: the controller is either free or waiting on ctrl_mem.
  typedef enum logic [0:0] {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_store.sv
// Line storage for the direct-mapped icache: valid flops plus tag/data arrays.
// Latency: async read port; writes and clears land on the next clock edge.
// Backpressure: none, the single write port is always accepted.
module icache_store import icache_ctrl_pkg::*; #(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = ICACHE_ADDR_WIDTH - 2 - ICACHE_INDEX_BITS,
  parameter int DATA_WIDTH = ICACHE_DATA_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_vld_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_dat_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  // Invalidate wipes every line and wins over a fill in the same cycle.
  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  // Valid bits are the only storage that needs a reset value.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign rd_vld_o = valid_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
  assign rd_dat_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped one-word-per-line icache between IF and ctrl_mem's instruction port.
// Latency: hit 1 cycle; miss = ctrl_mem latency + 1 cycle.
// Backpressure: IF holds if_read until if_ready/if_discard; ctrl_mem request held until ram_ready.
module icache_ctrl import icache_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  inv_i,
  input  logic                  if_read_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_discard_i,
  output logic                  if_ready_o,
  output logic [31:0]           if_data_o,
  output logic                  if_busy_o,
  output logic                  ram_read_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_discard_o,
  input  logic                  ram_ready_i,
  input  logic [31:0]           ram_data_i
);

  localparam int TAG_BITS = ADDR_WIDTH - 2 - INDEX_BITS;

  icache_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  if_ready_q, if_ready_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  ram_read_q, ram_read_d;
  logic                  ram_discard_q, ram_discard_d;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  line_vld;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_dat;
  logic                  hit;
  logic                  accept;
  logic                  fill_en;
  logic                  unused_addr_bits;

  // Byte offset is irrelevant for word fetches.
  assign unused_addr_bits = ^if_addr_i[1:0];

  assign lookup_idx = if_addr_i[INDEX_BITS+1:2];
  assign lookup_tag = if_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit        = line_vld && (line_tag == lookup_tag);

  // The !if_ready_q term stops a request still held during the answer cycle from being served twice.
  assign accept  = (state_q == ICACHE_IDLE) && if_read_i && !if_discard_i && !if_ready_q;
  // A fill that races a discard is dropped rather than cached; the word is never returned anyway.
  assign fill_en = (state_q == ICACHE_REFILL) && ram_ready_i && !if_discard_i;

  icache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (32)
  ) u_store (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear_i  (inv_i),
    .rd_idx_i (lookup_idx),
    .rd_vld_o (line_vld),
    .rd_tag_o (line_tag),
    .rd_dat_o (line_dat),
    .wr_en_i  (fill_en),
    .wr_idx_i (req_addr_q[INDEX_BITS+1:2]),
    .wr_tag_i (req_addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
    .wr_dat_i (ram_data_i)
  );

  // State register; reset mid-refill simply returns to IDLE.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= ICACHE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a miss starts a refill, which ends on ram_ready or discard.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ICACHE_IDLE: begin
        if (accept && !hit) begin
          state_d = ICACHE_REFILL;
        end
      end
      ICACHE_REFILL: begin
        if (if_discard_i || ram_ready_i) begin
          state_d = ICACHE_IDLE;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  // Next values of the registered outputs and the request latch.
  always_comb begin
    if_ready_d    = 1'b0;
    if_data_d     = if_data_q;
    ram_read_d    = 1'b0;
    ram_discard_d = 1'b0;
    req_addr_d    = req_addr_q;
    case (state_q)
      ICACHE_IDLE: begin
        if (accept) begin
          if (hit) begin
            if_ready_d = 1'b1;
            if_data_d  = line_dat;
          end else begin
            ram_read_d = 1'b1;
            req_addr_d = {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end
      ICACHE_REFILL: begin
        if (if_discard_i) begin
          ram_discard_d = 1'b1;
        end else if (ram_ready_i) begin
          if_ready_d = 1'b1;
          if_data_d  = ram_data_i;
        end else begin
          ram_read_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and request registers.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if_ready_q    <= 1'b0;
      if_data_q     <= '0;
      ram_read_q    <= 1'b0;
      ram_discard_q <= 1'b0;
      req_addr_q    <= '0;
    end else begin
      if_ready_q    <= if_ready_d;
      if_data_q     <= if_data_d;
      ram_read_q    <= ram_read_d;
      ram_discard_q <= ram_discard_d;
      req_addr_q    <= req_addr_d;
    end
  end

  assign if_ready_o    = if_ready_q;
  assign if_data_o     = if_data_q;
  assign if_busy_o     = ram_read_q;
  assign ram_read_o    = ram_read_q;
  assign ram_addr_o    = req_addr_q;
  assign ram_discard_o = ram_discard_q;

  // IF must hold its address while a refill is outstanding.
  a_addr_stable: assert property (@(posedge clock_i) disable iff (!reset_i)
    (state_q == ICACHE_REFILL && !if_discard_i) |->
      (if_addr_i[ADDR_WIDTH-1:2] == req_addr_q[ADDR_WIDTH-1:2]));

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: hits, misses, conflicts, discard, invalidate, reset.
// Latency: checks hit = 1 cycle and miss = ram latency + 1.
// Backpressure: bench plays both IF and ctrl_mem by hand.
module tb_icache_ctrl;

  logic        clock;
  logic        reset;
  logic        inv;
  logic        if_read;
  logic [31:0] if_addr;
  logic        if_discard;
  logic        if_ready;
  logic [31:0] if_data;
  logic        if_busy;
  logic        ram_read;
  logic [31:0] ram_addr;
  logic        ram_discard;
  logic        ram_ready;
  logic [31:0] ram_data;

  int checks = 0;
  int errors = 0;

  // {if_ready, if_busy, ram_read, ram_discard}
  wire [3:0] flags = {if_ready, if_busy, ram_read, ram_discard};

  icache_ctrl dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .inv_i         (inv),
    .if_read_i     (if_read),
    .if_addr_i     (if_addr),
    .if_discard_i  (if_discard),
    .if_ready_o    (if_ready),
    .if_data_o     (if_data),
    .if_busy_o     (if_busy),
    .ram_read_o    (ram_read),
    .ram_addr_o    (ram_addr),
    .ram_discard_o (ram_discard),
    .ram_ready_i   (ram_ready),
    .ram_data_i    (ram_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    cyc();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 0000", flags);
    end
    checks++;
    if (if_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h expected 00000000", if_data);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_cold_miss();
    int bad;
    if_read = 1'b1;
    if_addr = 32'h100;
    cyc();
    checks++;
    if (flags !== 4'b0110) begin
      errors++;
      $display("FAIL cold_req_flags got %b expected 0110", flags);
    end
    checks++;
    if (ram_addr !== 32'h100) begin
      errors++;
      $display("FAIL cold_ram_addr got %h expected 00000100", ram_addr);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (flags !== 4'b0110 || ram_addr !== 32'h100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cold_hold got %0d unstable cycles expected 0", bad);
    end
    ram_ready = 1'b1;
    ram_data  = 32'hDEADBEEF;
    cyc();
    ram_ready = 1'b0;
    ram_data  = 32'h0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cold_fill got flags %b data %h expected 1000 deadbeef", flags, if_data);
    end
    // if_read still held in the answer cycle: must not be answered again
    cyc();
    if_read = 1'b0;
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL cold_single_pulse got %b expected 0000", flags);
    end
    cyc();
  endtask

  task automatic test_hit();
    if_read = 1'b1;
    if_addr = 32'h100;
    cyc();
    if_read = 1'b0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hit got flags %b data %h expected 1000 deadbeef", flags, if_data);
    end
    cyc();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL hit_pulse_end got %b expected 0000", flags);
    end
    // discard in IDLE blocks even a hit
    if_read    = 1'b1;
    if_discard = 1'b1;
    cyc();
    if_read    = 1'b0;
    if_discard = 1'b0;
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL idle_discard got %b expected 0000", flags);
    end
    // stale ram_ready in IDLE is ignored
    ram_ready = 1'b1;
    ram_data  = 32'h12345678;
    cyc();
    ram_ready = 1'b0;
    checks++;
    if (flags !== 4'b0000 || if_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stale_ready got flags %b data %h expected 0000 deadbeef", flags, if_data);
    end
    cyc();
  endtask

  task automatic test_conflict();
    if_read = 1'b1;
    if_addr = 32'h300;
    cyc();
    checks++;
    if (flags !== 4'b0110 || ram_addr !== 32'h300) begin
      errors++;
      $display("FAIL conflict_miss got flags %b addr %h expected 0110 00000300", flags, ram_addr);
    end
    cyc();
    ram_ready = 1'b1;
    ram_data  = 32'h11110300;
    cyc();
    ram_ready = 1'b0;
    if_read   = 1'b0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'h11110300) begin
      errors++;
      $display("FAIL conflict_fill got flags %b data %h expected 1000 11110300", flags, if_data);
    end
    cyc();
    if_read = 1'b1;
    cyc();
    if_read = 1'b0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'h11110300) begin
      errors++;
      $display("FAIL conflict_hit got flags %b data %h expected 1000 11110300", flags, if_data);
    end
    cyc();
    if_read = 1'b1;
    if_addr = 32'h100;
    cyc();
    checks++;
    if (flags !== 4'b0110 || ram_addr !== 32'h100) begin
      errors++;
      $display("FAIL conflict_evict got flags %b addr %h expected 0110 00000100", flags, ram_addr);
    end
    ram_ready = 1'b1;
    ram_data  = 32'hDEADBEEF;
    cyc();
    ram_ready = 1'b0;
    if_read   = 1'b0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL conflict_refill got flags %b data %h expected 1000 deadbeef", flags, if_data);
    end
    cyc();
  endtask

  task automatic test_discard();
    if_read = 1'b1;
    if_addr = 32'h204;
    cyc();
    checks++;
    if (flags !== 4'b0110 || ram_addr !== 32'h204) begin
      errors++;
      $display("FAIL disc_miss got flags %b addr %h expected 0110 00000204", flags, ram_addr);
    end
    cyc();
    if_discard = 1'b1;
    cyc();
    if_discard = 1'b0;
    if_read    = 1'b0;
    checks++;
    if (flags !== 4'b0001) begin
      errors++;
      $display("FAIL disc_abort got %b expected 0001", flags);
    end
    cyc();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL disc_pulse_end got %b expected 0000", flags);
    end
    if_read = 1'b1;
    cyc();
    checks++;
    if (flags !== 4'b0110) begin
      errors++;
      $display("FAIL disc_still_miss got %b expected 0110", flags);
    end
    // discard coincident with ram_ready: word never returned
    if_discard = 1'b1;
    ram_ready  = 1'b1;
    ram_data   = 32'h0204CAFE;
    cyc();
    if_discard = 1'b0;
    ram_ready  = 1'b0;
    if_read    = 1'b0;
    checks++;
    if (flags !== 4'b0001) begin
      errors++;
      $display("FAIL disc_with_ready got %b expected 0001", flags);
    end
    cyc();
  endtask

  task automatic test_invalidate();
    if_read = 1'b1;
    if_addr = 32'h104;
    cyc();
    ram_ready = 1'b1;
    ram_data  = 32'hCAFE0104;
    cyc();
    ram_ready = 1'b0;
    if_read   = 1'b0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'hCAFE0104) begin
      errors++;
      $display("FAIL inv_fill104 got flags %b data %h expected 1000 cafe0104", flags, if_data);
    end
    cyc();
    // hit looked up alongside inv is still served
    if_read = 1'b1;
    if_addr = 32'h100;
    inv     = 1'b1;
    cyc();
    inv     = 1'b0;
    if_read = 1'b0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL inv_same_cycle_hit got flags %b data %h expected 1000 deadbeef", flags, if_data);
    end
    cyc();
    if_read = 1'b1;
    cyc();
    checks++;
    if (flags !== 4'b0110) begin
      errors++;
      $display("FAIL inv_100_miss got %b expected 0110", flags);
    end
    if_discard = 1'b1;
    cyc();
    if_discard = 1'b0;
    if_read    = 1'b0;
    cyc();
    if_read = 1'b1;
    if_addr = 32'h104;
    cyc();
    checks++;
    if (flags !== 4'b0110) begin
      errors++;
      $display("FAIL inv_104_miss got %b expected 0110", flags);
    end
    // inv coincident with the fill: word returned but the line stays invalid
    ram_ready = 1'b1;
    ram_data  = 32'hBEEF0104;
    inv       = 1'b1;
    cyc();
    ram_ready = 1'b0;
    inv       = 1'b0;
    if_read   = 1'b0;
    checks++;
    if (flags !== 4'b1000 || if_data !== 32'hBEEF0104) begin
      errors++;
      $display("FAIL inv_race_return got flags %b data %h expected 1000 beef0104", flags, if_data);
    end
    cyc();
    if_read = 1'b1;
    cyc();
    checks++;
    if (flags !== 4'b0110) begin
      errors++;
      $display("FAIL inv_race_not_valid got %b expected 0110", flags);
    end
    if_discard = 1'b1;
    cyc();
    if_discard = 1'b0;
    if_read    = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_refill();
    if_read = 1'b1;
    if_addr = 32'h100;
    cyc();
    ram_ready = 1'b1;
    ram_data  = 32'hDEADBEEF;
    cyc();
    ram_ready = 1'b0;
    if_read   = 1'b0;
    cyc();
    if_read = 1'b1;
    if_addr = 32'h180;
    cyc();
    checks++;
    if (flags !== 4'b0110 || ram_addr !== 32'h180) begin
      errors++;
      $display("FAIL rst_pre_miss got flags %b addr %h expected 0110 00000180", flags, ram_addr);
    end
    reset   = 1'b0;
    if_read = 1'b0;
    cyc();
    reset = 1'b1;
    checks++;
    if (flags !== 4'b0000 || if_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_refill got flags %b data %h expected 0000 00000000", flags, if_data);
    end
    cyc();
    if_read = 1'b1;
    if_addr = 32'h100;
    cyc();
    checks++;
    if (flags !== 4'b0110) begin
      errors++;
      $display("FAIL rst_lines_invalid got %b expected 0110", flags);
    end
    if_discard = 1'b1;
    cyc();
    if_discard = 1'b0;
    if_read    = 1'b0;
    cyc();
  endtask

  initial begin
    reset      = 1'b0;
    inv        = 1'b0;
    if_read    = 1'b0;
    if_addr    = 32'h0;
    if_discard = 1'b0;
    ram_ready  = 1'b0;
    ram_data   = 32'h0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_discard();
    test_invalidate();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
